systolic_result_collector: RTL and testbench

Avalon-ST sink that terminates the 128-bit `data_out` stream of `systolic_array_top` and buffers result beats in on-chip storage. The host reads buffered results, fill status and a completion flag through a 32-bit Avalon-MM CSR slave. It sits between the array output and the host bus, in place of a bench or DMA consumer.

---
 rtl/systolic_result_collector.sv | 101 ++++++++++
 tb/tb_systolic_result_collector.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/systolic_result_collector.sv
// Result sink for systolic_array_top: buffers up to DEPTH stream beats and
// exposes them, plus fill status and a completion flag, over a 32-bit CSR port.
module systolic_result_collector #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16
) (
    input  logic              clock_sink,
    input  logic              reset_sink_reset,
    input  logic [DATA_W-1:0] data_in_data,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    input  logic [7:0]        csr_address,
    input  logic              csr_read,
    output logic [31:0]       csr_readdata,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic              done
);

    // Stream handshake: a beat transfers on a rising edge where
    // data_in_valid and data_in_ready are both high; nothing else moves it.
    localparam int WPB = DATA_W / 32;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, wr_ptr_nxt;
    logic [CW-1:0]     count, count_nxt;
    logic [15:0]       expect_cnt, expect_nxt;
    logic              done_nxt;
    logic              accept, clear, expect_wr;
    logic              full, empty;
    logic [31:0]       rd_val;
    logic [DATA_W-1:0] rd_line;
    int                rd_beat, rd_word;
    logic              unused_wdata;

    assign unused_wdata = ^csr_writedata[31:16];

    assign accept    = data_in_valid && data_in_ready;
    assign clear     = csr_write && (csr_address == 8'h01) && csr_writedata[0];
    assign expect_wr = csr_write && (csr_address == 8'h02);
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);

    // Clear has priority: a beat handshaked on the clearing edge is dropped.
    always_comb begin
        count_nxt  = count;
        wr_ptr_nxt = wr_ptr;
        if (clear) begin
            count_nxt  = '0;
            wr_ptr_nxt = '0;
        end else if (accept) begin
            count_nxt  = count + 1'b1;
            wr_ptr_nxt = wr_ptr + 1'b1;
        end
        expect_nxt = expect_wr ? csr_writedata[15:0] : expect_cnt;
        done_nxt   = (expect_nxt != 16'd0) && (16'(count_nxt) >= expect_nxt);
    end

    always_comb begin
        rd_val  = '0;
        rd_beat = int'(csr_address[5:0]) / WPB;
        rd_word = int'(csr_address[5:0]) % WPB;
        rd_line = mem[rd_beat[AW-1:0]];
        if (csr_address[7:6] == 2'b01) begin
            if (rd_beat < int'(count)) rd_val = rd_line[rd_word*32 +: 32];
        end else begin
            case (csr_address)
                8'h00:   rd_val = {13'd0, done, empty, full, 16'(count)};
                8'h02:   rd_val = {16'd0, expect_cnt};
                default: rd_val = '0;
            endcase
        end
    end

    // Storage is deliberately left out of reset; stale beats are masked by count.
    always_ff @(posedge clock_sink) begin
        if (accept) mem[wr_ptr] <= data_in_data;
    end

    always_ff @(posedge clock_sink or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            wr_ptr        <= '0;
            count         <= '0;
            expect_cnt    <= '0;
            done          <= 1'b0;
            data_in_ready <= 1'b0;
            csr_readdata  <= '0;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            count         <= count_nxt;
            expect_cnt    <= expect_nxt;
            done          <= done_nxt;
            data_in_ready <= (count_nxt != FULL_CNT);
            if (csr_read) csr_readdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed bench for systolic_result_collector: streaming, back-pressure,
// CSR readback, clear races and asynchronous reset mid-stream.
module tb_systolic_result_collector;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] data_in_data = '0;
    logic         data_in_valid = 1'b0;
    logic         data_in_ready;
    logic [7:0]   csr_address = '0;
    logic         csr_read = 1'b0;
    logic [31:0]  csr_readdata;
    logic         csr_write = 1'b0;
    logic [31:0]  csr_writedata = '0;
    logic         done;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] rd;
    logic [7:0]  vpat [5];

    systolic_result_collector #(.DATA_W(128), .DEPTH(16)) dut (
        .clock_sink       (clk),
        .reset_sink_reset (rst),
        .data_in_data     (data_in_data),
        .data_in_valid    (data_in_valid),
        .data_in_ready    (data_in_ready),
        .csr_address      (csr_address),
        .csr_read         (csr_read),
        .csr_readdata     (csr_readdata),
        .csr_write        (csr_write),
        .csr_writedata    (csr_writedata),
        .done             (done)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] beat(input logic [7:0] v);
        return {16{v}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
        csr_address   = a;
        csr_writedata = d;
        csr_write     = 1'b1;
        step();
        csr_write     = 1'b0;
    endtask

    task automatic csr_rd(input logic [7:0] a, output logic [31:0] d);
        csr_address = a;
        csr_read    = 1'b1;
        step();
        csr_read    = 1'b0;
        d           = csr_readdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        check("rst_ready", 32'(data_in_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_readdata", csr_readdata, 32'd0);
        rst = 1'b0;
        check("ready_before_edge", 32'(data_in_ready), 32'd0);
        step();
        check("ready_first_edge", 32'(data_in_ready), 32'd1);

        // Fill all 16 beats with valid held high
        csr_wr(8'h02, 32'd16);
        data_in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            data_in_data = beat(8'(k + 1));
            check($sformatf("ready_fill_%0d", k), 32'(data_in_ready), 32'd1);
            step();
        end
        check("ready_full", 32'(data_in_ready), 32'd0);
        check("done_full", 32'(done), 32'd1);

        // Offer a 17th beat for 5 cycles
        data_in_data = beat(8'h11);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("ready_bp_%0d", k), 32'(data_in_ready), 32'd0);
        end
        data_in_valid = 1'b0;

        csr_rd(8'h00, rd);  check("status_full", rd, 32'h0005_0010);
        csr_rd(8'h4D, rd);  check("data_b3_w1", rd, 32'h0404_0404);
        step(); step();
        check("readdata_hold", csr_readdata, 32'h0404_0404);
        csr_rd(8'h7C, rd);  check("data_b15_w0", rd, 32'h1010_1010);
        csr_rd(8'h7F, rd);  check("data_b15_w3", rd, 32'h1010_1010);
        csr_rd(8'h05, rd);  check("unmapped", rd, 32'd0);
        csr_rd(8'h02, rd);  check("expect_rb", rd, 32'd16);
        csr_wr(8'h00, 32'd0);
        csr_rd(8'h00, rd);  check("status_ro", rd, 32'h0005_0010);

        // Clear, then toggled valid with EXPECT=3
        csr_wr(8'h01, 32'd1);
        step();
        check("ready_after_clear", 32'(data_in_ready), 32'd1);
        csr_rd(8'h00, rd);  check("status_cleared", rd, 32'h0002_0000);
        csr_wr(8'h02, 32'd3);
        vpat[0] = 8'd1; vpat[1] = 8'd0; vpat[2] = 8'd1; vpat[3] = 8'd1; vpat[4] = 8'd0;
        for (int i = 0; i < 5; i++) begin
            data_in_valid = vpat[i][0];
            data_in_data  = beat(8'(i + 1));
            step();
            check($sformatf("done_toggle_%0d", i), 32'(done), (i >= 3) ? 32'd1 : 32'd0);
        end
        data_in_valid = 1'b0;
        csr_rd(8'h00, rd);  check("status_three", rd, 32'h0004_0003);
        csr_rd(8'h48, rd);  check("data_b2_w0", rd, 32'h0404_0404);
        csr_rd(8'h4C, rd);  check("data_beyond_count", rd, 32'd0);

        // Clear on the same edge as an accepted beat
        data_in_valid = 1'b1;
        data_in_data  = beat(8'h20);
        csr_wr(8'h01, 32'd1);
        data_in_valid = 1'b0;
        csr_rd(8'h00, rd);  check("status_clear_race", rd, 32'h0002_0000);
        csr_rd(8'h40, rd);  check("data_clear_race", rd, 32'd0);

        // Asynchronous reset after 7 accepted beats
        csr_wr(8'h02, 32'd7);
        data_in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            data_in_data = beat(8'(k + 8'h30));
            step();
        end
        check("done_seven", 32'(done), 32'd1);
        check("ready_seven", 32'(data_in_ready), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("async_ready", 32'(data_in_ready), 32'd0);
        check("async_done", 32'(done), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        check("ready_held_low", 32'(data_in_ready), 32'd0);
        step();
        data_in_valid = 1'b0;
        check("ready_after_rst", 32'(data_in_ready), 32'd1);
        check("readdata_after_rst", csr_readdata, 32'd0);
        csr_rd(8'h00, rd);  check("status_after_rst", rd, 32'h0002_0000);
        csr_rd(8'h02, rd);  check("expect_after_rst", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
